// File: rtl/sd_access_arbiter.sv
// sd_access_arbiter: round-robin access to one SD sector controller for a
// writer (W) and a reader (R) client. One sector per grant. The controller
// start pulse is issued, its busy handshake is tracked, and a done pulse goes
// back to the owning client. A controller that never raises busy is flagged.
module sd_access_arbiter #(
  parameter int BUSY_WAIT = 8,
  parameter int CNT_W     = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sd_init_done,
  input  logic        w_req,
  input  logic [31:0] w_addr,
  output logic        w_grant,
  output logic        w_done,
  input  logic        r_req,
  input  logic [31:0] r_addr,
  output logic        r_grant,
  output logic        r_done,
  output logic        wr_start_en,
  output logic [31:0] wr_sec_addr,
  input  logic        wr_busy,
  output logic        rd_start_en,
  output logic [31:0] rd_sec_addr,
  input  logic        rd_busy,
  output logic        err_timeout,
  output logic [1:0]  o_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    START   = 2'b01,
    WAIT_HI = 2'b10,
    WAIT_LO = 2'b11
  } state_t;

  localparam logic             OP_W     = 1'b0;
  localparam logic             OP_R     = 1'b1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_WAIT - 1);

  state_t           r_state,     w_state_nxt;
  logic             r_op,        w_op_nxt;
  logic             r_last_op,   w_last_op_nxt;
  logic [CNT_W-1:0] r_cnt,       w_cnt_nxt;
  logic             r_w_grant,   w_w_grant_nxt;
  logic             r_r_grant,   w_r_grant_nxt;
  logic             r_wr_start,  w_wr_start_nxt;
  logic             r_rd_start,  w_rd_start_nxt;
  logic             r_w_done,    w_w_done_nxt;
  logic             r_r_done,    w_r_done_nxt;
  logic             r_err,       w_err_nxt;
  logic [31:0]      r_wr_addr,   w_wr_addr_nxt;
  logic [31:0]      r_rd_addr,   w_rd_addr_nxt;

  logic w_sel_busy;
  logic w_pick;

  // Busy of the controller port owned by the current operation; the other
  // port's busy is deliberately ignored mid-transaction.
  assign w_sel_busy = (r_op == OP_R) ? rd_busy : wr_busy;

  // On a tie the client that did not go last wins; otherwise the sole requester.
  assign w_pick = (w_req && r_req) ? ~r_last_op : (r_req ? OP_R : OP_W);

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_op       <= OP_W;
      r_last_op  <= OP_R;
      r_cnt      <= '0;
      r_w_grant  <= 1'b0;
      r_r_grant  <= 1'b0;
      r_wr_start <= 1'b0;
      r_rd_start <= 1'b0;
      r_w_done   <= 1'b0;
      r_r_done   <= 1'b0;
      r_err      <= 1'b0;
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_op       <= w_op_nxt;
      r_last_op  <= w_last_op_nxt;
      r_cnt      <= w_cnt_nxt;
      r_w_grant  <= w_w_grant_nxt;
      r_r_grant  <= w_r_grant_nxt;
      r_wr_start <= w_wr_start_nxt;
      r_rd_start <= w_rd_start_nxt;
      r_w_done   <= w_w_done_nxt;
      r_r_done   <= w_r_done_nxt;
      r_err      <= w_err_nxt;
      r_wr_addr  <= w_wr_addr_nxt;
      r_rd_addr  <= w_rd_addr_nxt;
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_op_nxt       = r_op;
    w_last_op_nxt  = r_last_op;
    w_cnt_nxt      = r_cnt;
    w_w_grant_nxt  = 1'b0;
    w_r_grant_nxt  = 1'b0;
    w_wr_start_nxt = 1'b0;
    w_rd_start_nxt = 1'b0;
    w_w_done_nxt   = 1'b0;
    w_r_done_nxt   = 1'b0;
    w_err_nxt      = 1'b0;
    w_wr_addr_nxt  = r_wr_addr;
    w_rd_addr_nxt  = r_rd_addr;

    if (!sd_init_done) begin
      // Controller not ready: abandon any transaction silently.
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (!wr_busy && !rd_busy && (w_req || r_req)) begin
            w_op_nxt      = w_pick;
            w_last_op_nxt = w_pick;
            if (w_pick == OP_W) begin
              w_wr_addr_nxt = w_addr;
              w_w_grant_nxt = 1'b1;
            end else begin
              w_rd_addr_nxt = r_addr;
              w_r_grant_nxt = 1'b1;
            end
            w_state_nxt = START;
          end
        end
        START: begin
          w_wr_start_nxt = (r_op == OP_W);
          w_rd_start_nxt = (r_op == OP_R);
          w_cnt_nxt      = '0;
          w_state_nxt    = WAIT_HI;
        end
        WAIT_HI: begin
          if (w_sel_busy) begin
            w_state_nxt = WAIT_LO;
          end else if (r_cnt == CNT_LAST) begin
            w_err_nxt    = 1'b1;
            w_w_done_nxt = (r_op == OP_W);
            w_r_done_nxt = (r_op == OP_R);
            w_state_nxt  = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        WAIT_LO: begin
          if (!w_sel_busy) begin
            w_w_done_nxt = (r_op == OP_W);
            w_r_done_nxt = (r_op == OP_R);
            w_state_nxt  = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  assign w_grant     = r_w_grant;
  assign r_grant     = r_r_grant;
  assign wr_start_en = r_wr_start;
  assign rd_start_en = r_rd_start;
  assign w_done      = r_w_done;
  assign r_done      = r_r_done;
  assign err_timeout = r_err;
  assign wr_sec_addr = r_wr_addr;
  assign rd_sec_addr = r_rd_addr;
  assign o_state     = r_state;

endmodule

// File: tb/tb_sd_access_arbiter.sv
// Testbench for sd_access_arbiter: table of per-cycle vectors plus
// hand-written multi-cycle sequences.
module tb_sd_access_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sd_init_done = 1'b0;
  logic        w_req = 1'b0, r_req = 1'b0;
  logic [31:0] w_addr = '0, r_addr = '0;
  logic        wr_busy = 1'b0, rd_busy = 1'b0;
  logic        w_grant, w_done, r_grant, r_done;
  logic        wr_start_en, rd_start_en, err_timeout;
  logic [31:0] wr_sec_addr, rd_sec_addr;
  logic [1:0]  o_state;

  int n_cmp = 0;
  int n_fail = 0;

  sd_access_arbiter #(.BUSY_WAIT(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sd_init_done(sd_init_done),
    .w_req(w_req), .w_addr(w_addr), .w_grant(w_grant), .w_done(w_done),
    .r_req(r_req), .r_addr(r_addr), .r_grant(r_grant), .r_done(r_done),
    .wr_start_en(wr_start_en), .wr_sec_addr(wr_sec_addr), .wr_busy(wr_busy),
    .rd_start_en(rd_start_en), .rd_sec_addr(rd_sec_addr), .rd_busy(rd_busy),
    .err_timeout(err_timeout), .o_state(o_state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       init, wq, rq, wb, rb;
    logic [8:0] exp;  // {w_grant,r_grant,wr_start,rd_start,w_done,r_done,err,state[1:0]}
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mk(input logic [4:0] in, input logic [6:0] pulses, input logic [1:0] st);
    vec_t v;
    v.init = in[4]; v.wq = in[3]; v.rq = in[2]; v.wb = in[1]; v.rb = in[0];
    v.exp  = {pulses, st};
    return v;
  endfunction

  function automatic logic [8:0] outs();
    return {w_grant, r_grant, wr_start_en, rd_start_en, w_done, r_done, err_timeout, o_state};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int g_cyc, s_cyc, d_cyc, e_cyc, g_cnt, s_cnt, d_cnt, e_cnt, other_cnt;

  task automatic clr_rec();
    g_cyc = -1; s_cyc = -1; d_cyc = -1; e_cyc = -1;
    g_cnt = 0; s_cnt = 0; d_cnt = 0; e_cnt = 0; other_cnt = 0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("reset_outputs", {55'd0, outs()}, 64'd0);
    chk("reset_addrs", {wr_sec_addr, rd_sec_addr}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Per-cycle arbitration table: {init,wq,rq,wb,rb}, pulses, state
    tbl[0]  = mk(5'b10000, 7'b0000000, 2'b00);
    tbl[1]  = mk(5'b11100, 7'b1000000, 2'b01);  // tie -> W first
    tbl[2]  = mk(5'b10100, 7'b0010000, 2'b10);
    tbl[3]  = mk(5'b10110, 7'b0000000, 2'b11);
    tbl[4]  = mk(5'b10110, 7'b0000000, 2'b11);
    tbl[5]  = mk(5'b10100, 7'b0000100, 2'b00);
    tbl[6]  = mk(5'b11100, 7'b0100000, 2'b01);  // tie -> R
    tbl[7]  = mk(5'b11000, 7'b0001000, 2'b10);
    tbl[8]  = mk(5'b11010, 7'b0000000, 2'b10);  // wr_busy ignored during R
    tbl[9]  = mk(5'b11001, 7'b0000000, 2'b11);
    tbl[10] = mk(5'b11001, 7'b0000000, 2'b11);
    tbl[11] = mk(5'b11100, 7'b0000010, 2'b00);
    tbl[12] = mk(5'b11100, 7'b1000000, 2'b01);  // tie -> W
    tbl[13] = mk(5'b10100, 7'b0010000, 2'b10);
    tbl[14] = mk(5'b10110, 7'b0000000, 2'b11);
    tbl[15] = mk(5'b10100, 7'b0000100, 2'b00);
    tbl[16] = mk(5'b11100, 7'b0100000, 2'b01);  // tie -> R
    tbl[17] = mk(5'b10000, 7'b0001000, 2'b10);
    tbl[18] = mk(5'b10001, 7'b0000000, 2'b11);
    tbl[19] = mk(5'b10000, 7'b0000010, 2'b00);
    tbl[20] = mk(5'b11111, 7'b0000000, 2'b00);  // both busy: no grant
    tbl[21] = mk(5'b10000, 7'b0000000, 2'b00);
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      sd_init_done = tbl[i].init; w_req = tbl[i].wq; r_req = tbl[i].rq;
      wr_busy = tbl[i].wb; rd_busy = tbl[i].rb;
      tick();
      chk($sformatf("vec%0d", i), {55'd0, outs()}, {55'd0, tbl[i].exp});
    end

    // W-only sector with busy pulse of 20 cycles
    clr_rec();
    r_addr = 32'hAAAA_5555;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      w_req   = (c <= 2);
      w_addr  = (c == 1) ? 32'h0000_07D1 : 32'hFFFF_0000;
      r_req   = 1'b0;
      wr_busy = (c >= 4 && c <= 23);
      tick();
      if (w_grant) begin g_cnt++; g_cyc = c; end
      if (wr_start_en) begin s_cnt++; s_cyc = c; end
      if (w_done) begin d_cnt++; d_cyc = c; end
      if (rd_start_en || r_grant || r_done || err_timeout) other_cnt++;
    end
    chk("wonly_grant_cyc", g_cyc, 1);
    chk("wonly_start_cyc", s_cyc, 2);
    chk("wonly_done_cyc", d_cyc, 24);
    chk("wonly_counts", {g_cnt[15:0], s_cnt[15:0], d_cnt[15:0]}, {16'd1, 16'd1, 16'd1});
    chk("wonly_no_r_activity", other_cnt, 0);
    chk("wonly_wr_addr", wr_sec_addr, 32'h0000_07D1);
    chk("wonly_rd_addr_held", rd_sec_addr, 32'h0000_0000);
    chk("wonly_state", o_state, 2'b00);

    // R timeout: rd_busy never rises
    clr_rec();
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      r_req  = (c <= 2);
      r_addr = (c == 1) ? 32'h0000_1234 : 32'h0BAD_0BAD;
      tick();
      if (r_grant) begin g_cnt++; g_cyc = c; end
      if (rd_start_en) begin s_cnt++; s_cyc = c; end
      if (r_done) begin d_cnt++; d_cyc = c; end
      if (err_timeout) begin e_cnt++; e_cyc = c; end
      if (wr_start_en || w_grant || w_done) other_cnt++;
    end
    chk("to_grant_cyc", g_cyc, 1);
    chk("to_start_cyc", s_cyc, 2);
    chk("to_start_cnt", s_cnt, 1);
    chk("to_err_cyc", e_cyc, 10);
    chk("to_done_cyc", d_cyc, 10);
    chk("to_pulse_cnts", {e_cnt[15:0], d_cnt[15:0]}, {16'd1, 16'd1});
    chk("to_no_w_activity", other_cnt, 0);
    chk("to_rd_addr", rd_sec_addr, 32'h0000_1234);
    chk("to_wr_addr_held", wr_sec_addr, 32'h0000_07D1);
    chk("to_state", o_state, 2'b00);

    // Busy gating: rd_busy high blocks a W grant
    clr_rec();
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      w_req   = (g_cnt == 0);
      w_addr  = 32'h0000_0042;
      rd_busy = (c <= 5);
      wr_busy = (c >= 8 && c <= 9);
      tick();
      if (w_grant) begin g_cnt++; g_cyc = c; end
      if (w_done) begin d_cnt++; d_cyc = c; end
    end
    chk("gate_grant_cyc", g_cyc, 6);
    chk("gate_grant_cnt", g_cnt, 1);
    chk("gate_done_cyc", d_cyc, 10);
    chk("gate_state", o_state, 2'b00);

    // sd_init_done drop in WAIT_LO, then fresh grant
    clr_rec();
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      w_req        = (c <= 8);
      w_addr       = 32'h0000_0100 + c;
      sd_init_done = (c != 6);
      wr_busy      = (c >= 4 && c <= 6);
      rd_busy      = 1'b0;
      tick();
      if (c == 5) chk("init_in_wait_lo", o_state, 2'b11);
      if (c == 6) chk("init_drop_outputs", {55'd0, outs()}, 64'd0);
      if (w_grant) begin g_cnt++; g_cyc = c; end
      if (w_done) begin d_cnt++; d_cyc = c; end
      if (err_timeout) begin e_cnt++; e_cyc = c; end
    end
    chk("init_grant_cnt", g_cnt, 2);
    chk("init_regrant_cyc", g_cyc, 7);
    chk("init_done_only_after_regrant", {d_cnt[15:0], d_cyc[15:0]}, {16'd1, 16'd16});
    chk("init_err_cyc", e_cyc, 16);
    chk("init_wr_addr", wr_sec_addr, 32'h0000_0107);

    // Async reset mid-WAIT_HI; last transaction was W, so the tie after
    // reset must still go to W because reset restores last_op=R.
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      w_req = (c <= 2);
      tick();
    end
    chk("ar_in_wait_hi", o_state, 2'b10);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_outputs_now", {55'd0, outs()}, 64'd0);
    chk("ar_addrs_now", {wr_sec_addr, rd_sec_addr}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    w_req = 1'b1; r_req = 1'b1;
    tick();
    chk("ar_first_tie", {62'd0, w_grant, r_grant}, 64'b10);
    @(negedge clk);
    w_req = 1'b0; r_req = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
